// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded CPU control path.
//   opcode_e     : instruction register upper-nibble encodings
//   seq_state_e  : sequencer run/halt state
//   ctrl_word_t  : one microinstruction (active-low strobes plus alu_sub)
//   STEP_W       : width of the microstep counter
//   CTRL_IDLE    : control word with every strobe deasserted
package cpu_pkg;

  localparam int STEP_W = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic pc_cntn;
    logic pc_den;
    logic pc_din;
    logic mar_inn;
    logic ram_inn;
    logic ram_outn;
    logic ir_inn;
    logic ir_outn;
    logic a_inn;
    logic a_outn;
    logic b_inn;
    logic alu_outn;
    logic out_inn;
    logic alu_sub;
  } ctrl_word_t;

  // Thirteen active-low strobes high, alu_sub (the LSB) low.
  localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'({13'h1FFF, 1'b0});

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the instruction/flag sources and the control sequencer.
//   i_opcode, i_carry_flag, i_zero_flag, i_pc_overflow, i_resume : into sequencer
//   o_* strobes (active-low except o_alu_sub), o_step, o_halt   : out of sequencer
// master: the side that supplies opcode/flags and consumes strobes.
// slave : the control sequencer itself.
interface control_sequencer_if;

  logic [3:0] i_opcode;
  logic       i_carry_flag;
  logic       i_zero_flag;
  logic       i_pc_overflow;
  logic       i_resume;

  logic       o_pc_cntn;
  logic       o_pc_den;
  logic       o_pc_din;
  logic       o_mar_inn;
  logic       o_ram_inn;
  logic       o_ram_outn;
  logic       o_ir_inn;
  logic       o_ir_outn;
  logic       o_a_inn;
  logic       o_a_outn;
  logic       o_b_inn;
  logic       o_alu_outn;
  logic       o_out_inn;
  logic       o_alu_sub;
  logic [2:0] o_step;
  logic       o_halt;

  modport master (
    output i_opcode, i_carry_flag, i_zero_flag, i_pc_overflow, i_resume,
    input  o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_inn, o_ram_outn,
           o_ir_inn, o_ir_outn, o_a_inn, o_a_outn, o_b_inn, o_alu_outn,
           o_out_inn, o_alu_sub, o_step, o_halt
  );

  modport slave (
    input  i_opcode, i_carry_flag, i_zero_flag, i_pc_overflow, i_resume,
    output o_pc_cntn, o_pc_den, o_pc_din, o_mar_inn, o_ram_inn, o_ram_outn,
           o_ir_inn, o_ir_outn, o_a_inn, o_a_outn, o_b_inn, o_alu_outn,
           o_out_inn, o_alu_sub, o_step, o_halt
  );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word and a
// flag marking the last useful step of the current opcode.
//   opcode     : instruction upper nibble
//   step       : current microstep
//   carry_flag : gates JC at T2
//   zero_flag  : gates JZ at T2
//   ctrl       : control word for this step
//   last_step  : this step (or any later one) ends the instruction
module microcode_rom
  import cpu_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output ctrl_word_t        ctrl,
  output logic              last_step
);

  logic [STEP_W-1:0] last_idx;

  // NOTE: every output of this always_comb gets a default before the case
  // statements, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ctrl     = CTRL_IDLE;
    last_idx = 3'd1;

    // Index of the final step each opcode uses; conditional jumps always
    // spend T2 even when the branch is not taken.
    case (opcode)
      OP_LDA, OP_STA:  last_idx = 3'd3;
      OP_ADD, OP_SUB:  last_idx = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_idx = 3'd2;
      default:         last_idx = 3'd1;
    endcase

    case (step)
      3'd0: begin
        ctrl.pc_den  = 1'b0;
        ctrl.mar_inn = 1'b0;
      end
      3'd1: begin
        ctrl.ram_outn = 1'b0;
        ctrl.ir_inn   = 1'b0;
        ctrl.pc_cntn  = 1'b0;
      end
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_outn = 1'b0;
            ctrl.mar_inn = 1'b0;
          end
          OP_LDI: begin
            ctrl.ir_outn = 1'b0;
            ctrl.a_inn   = 1'b0;
          end
          OP_JMP: begin
            ctrl.ir_outn = 1'b0;
            ctrl.pc_din  = 1'b0;
          end
          OP_JC: begin
            if (carry_flag) begin
              ctrl.ir_outn = 1'b0;
              ctrl.pc_din  = 1'b0;
            end
          end
          OP_JZ: begin
            if (zero_flag) begin
              ctrl.ir_outn = 1'b0;
              ctrl.pc_din  = 1'b0;
            end
          end
          OP_OUT: begin
            ctrl.a_outn  = 1'b0;
            ctrl.out_inn = 1'b0;
          end
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_outn = 1'b0;
            ctrl.a_inn    = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_outn = 1'b0;
            ctrl.b_inn    = 1'b0;
            ctrl.alu_sub  = (opcode == OP_SUB);
          end
          OP_STA: begin
            ctrl.a_outn  = 1'b0;
            ctrl.ram_inn = 1'b0;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_outn = 1'b0;
          ctrl.a_inn    = 1'b0;
          ctrl.alu_sub  = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // ">=" rather than "==" so an opcode change mid-instruction that lands
  // beyond the new opcode's range still returns the counter to T0.
  assign last_step = (step >= last_idx);

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer for a bus-based 8-bit CPU.  Holds RUN/HALT state and a
// step counter; the control word is a combinational lookup in microcode_rom.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous active-high reset; forces all strobes deasserted
//   bus   : control_sequencer_if.slave (opcode/flags/resume in, strobes,
//           o_step and o_halt out)
// Parameters:
//   NUM_STEPS      : microsteps per instruction, 3..8
//   HALT_ON_PC_OVF : nonzero -> program counter overflow at T0 halts
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_STEPS      = 5,
  parameter int HALT_ON_PC_OVF = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  control_sequencer_if.slave   bus
);

  localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

  seq_state_e        state;
  logic [STEP_W-1:0] step;
  ctrl_word_t        rom_ctrl;
  logic              rom_last;
  ctrl_word_t        ctrl_out;
  logic              ovf_halt;
  logic              hlt_halt;

  microcode_rom u_rom (
    .opcode     (bus.i_opcode),
    .step       (step),
    .carry_flag (bus.i_carry_flag),
    .zero_flag  (bus.i_zero_flag),
    .ctrl       (rom_ctrl),
    .last_step  (rom_last)
  );

  assign ovf_halt = (HALT_ON_PC_OVF != 0) && bus.i_pc_overflow && (step == '0);
  // rom_last for HLT is only true from T2 on, so this fires at T2.
  assign hlt_halt = (bus.i_opcode == 4'(OP_HLT)) && rom_last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_RUN;
      step  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ovf_halt || hlt_halt) begin
            state <= ST_HALT;
            step  <= '0;
          end else if (rom_last || step == LAST_IDX) begin
            step <= '0;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        ST_HALT: begin
          step <= '0;
          if (bus.i_resume) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          step  <= '0;
        end
      endcase
    end
  end

  // Reset gates the word combinationally so strobes drop the instant i_rst
  // rises, without waiting for a clock edge.
  assign ctrl_out = (i_rst || state == ST_HALT) ? CTRL_IDLE : rom_ctrl;

  assign bus.o_pc_cntn  = ctrl_out.pc_cntn;
  assign bus.o_pc_den   = ctrl_out.pc_den;
  assign bus.o_pc_din   = ctrl_out.pc_din;
  assign bus.o_mar_inn  = ctrl_out.mar_inn;
  assign bus.o_ram_inn  = ctrl_out.ram_inn;
  assign bus.o_ram_outn = ctrl_out.ram_outn;
  assign bus.o_ir_inn   = ctrl_out.ir_inn;
  assign bus.o_ir_outn  = ctrl_out.ir_outn;
  assign bus.o_a_inn    = ctrl_out.a_inn;
  assign bus.o_a_outn   = ctrl_out.a_outn;
  assign bus.o_b_inn    = ctrl_out.b_inn;
  assign bus.o_alu_outn = ctrl_out.alu_outn;
  assign bus.o_out_inn  = ctrl_out.out_inn;
  assign bus.o_alu_sub  = ctrl_out.alu_sub;
  assign bus.o_step     = step;
  assign bus.o_halt     = (state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process pushes the
// hand-derived expected word/step/halt for each driven cycle; a monitor pops
// and compares mid-cycle.  A second monitor checks bus-driver exclusivity.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   tests_run;
  int   tests_failed;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] step;
    logic       halt;
    ctrl_word_t word;
  } exp_t;

  exp_t exp_q[$];

  control_sequencer_if bus ();

  control_sequencer #(
    .NUM_STEPS      (5),
    .HALT_ON_PC_OVF (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected control words, written out strobe by strobe.
  function automatic ctrl_word_t exp_word(input string k);
    ctrl_word_t c;
    c = '1;
    c.alu_sub = 1'b0;
    case (k)
      "T0":   begin c.pc_den = 1'b0;   c.mar_inn = 1'b0; end
      "T1":   begin c.ram_outn = 1'b0; c.ir_inn = 1'b0; c.pc_cntn = 1'b0; end
      "ADDR": begin c.ir_outn = 1'b0;  c.mar_inn = 1'b0; end
      "LDA3": begin c.ram_outn = 1'b0; c.a_inn = 1'b0; end
      "ADD3": begin c.ram_outn = 1'b0; c.b_inn = 1'b0; end
      "SUB3": begin c.ram_outn = 1'b0; c.b_inn = 1'b0; c.alu_sub = 1'b1; end
      "ADD4": begin c.alu_outn = 1'b0; c.a_inn = 1'b0; end
      "SUB4": begin c.alu_outn = 1'b0; c.a_inn = 1'b0; c.alu_sub = 1'b1; end
      "STA3": begin c.a_outn = 1'b0;   c.ram_inn = 1'b0; end
      "LDI2": begin c.ir_outn = 1'b0;  c.a_inn = 1'b0; end
      "JMP2": begin c.ir_outn = 1'b0;  c.pc_din = 1'b0; end
      "OUT2": begin c.a_outn = 1'b0;   c.out_inn = 1'b0; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_word_t sample_word();
    ctrl_word_t c;
    c.pc_cntn  = bus.o_pc_cntn;
    c.pc_den   = bus.o_pc_den;
    c.pc_din   = bus.o_pc_din;
    c.mar_inn  = bus.o_mar_inn;
    c.ram_inn  = bus.o_ram_inn;
    c.ram_outn = bus.o_ram_outn;
    c.ir_inn   = bus.o_ir_inn;
    c.ir_outn  = bus.o_ir_outn;
    c.a_inn    = bus.o_a_inn;
    c.a_outn   = bus.o_a_outn;
    c.b_inn    = bus.o_b_inn;
    c.alu_outn = bus.o_alu_outn;
    c.out_inn  = bus.o_out_inn;
    c.alu_sub  = bus.o_alu_sub;
    return c;
  endfunction

  // Drive one cycle's inputs (called #1 after a rising edge), queue the
  // expectation for this cycle, then advance to #1 after the next edge.
  task automatic drive(input string name, input logic [3:0] op,
                       input bit c, input bit z, input bit ovf, input bit res,
                       input bit rs, input int est, input bit eh, input string wk);
    exp_t e;
    bus.i_opcode      = op;
    bus.i_carry_flag  = c;
    bus.i_zero_flag   = z;
    bus.i_pc_overflow = ovf;
    bus.i_resume      = res;
    rst               = rs;
    e.cyc  = cyc;
    e.name = name;
    e.step = 3'(est);
    e.halt = eh;
    e.word = exp_word(wk);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  initial begin : scoreboard_mon
    exp_t       e;
    ctrl_word_t act;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e   = exp_q.pop_front();
        act = sample_word();
        check(e.name,
              act == e.word && bus.o_step == e.step && bus.o_halt == e.halt,
              {14'd0, bus.o_halt, bus.o_step, act},
              {14'd0, e.halt, e.step, e.word});
      end
    end
  end

  // Bus-driver exclusivity monitor.
  initial begin : bus_mon
    int n;
    forever begin
      @(negedge clk);
      n = $countones({~bus.o_pc_den, ~bus.o_ram_outn, ~bus.o_ir_outn,
                      ~bus.o_a_outn, ~bus.o_alu_outn});
      check("bus_onehot", n <= 1, 32'(n), 32'd1);
    end
  end

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    rst               = 1'b1;
    bus.i_opcode      = 4'h0;
    bus.i_carry_flag  = 1'b0;
    bus.i_zero_flag   = 1'b0;
    bus.i_pc_overflow = 1'b0;
    bus.i_resume      = 1'b0;
    @(posedge clk);
    #1;
    //     name           op    c  z  ov rs rst st h  word
    drive("reset",        4'h1, 0, 0, 0, 0, 1, 0, 0, "IDLE");
    // LDA; resume in RUN must be ignored
    drive("lda_t0",       4'h1, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("lda_t1_res",   4'h1, 0, 0, 0, 1, 0, 1, 0, "T1");
    drive("lda_t2",       4'h1, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("lda_t3",       4'h1, 0, 0, 0, 0, 0, 3, 0, "LDA3");
    // SUB, full five steps, then wrap
    drive("sub_t0",       4'h3, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("sub_t1",       4'h3, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("sub_t2",       4'h3, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("sub_t3",       4'h3, 0, 0, 0, 0, 0, 3, 0, "SUB3");
    drive("sub_t4",       4'h3, 0, 0, 0, 0, 0, 4, 0, "SUB4");
    // JC not taken, then taken
    drive("jc0_t0",       4'h7, 0, 1, 0, 0, 0, 0, 0, "T0");
    drive("jc0_t1",       4'h7, 0, 1, 0, 0, 0, 1, 0, "T1");
    drive("jc0_t2",       4'h7, 0, 1, 0, 0, 0, 2, 0, "IDLE");
    drive("jc1_t0",       4'h7, 1, 0, 0, 0, 0, 0, 0, "T0");
    drive("jc1_t1",       4'h7, 1, 0, 0, 0, 0, 1, 0, "T1");
    drive("jc1_t2",       4'h7, 1, 0, 0, 0, 0, 2, 0, "JMP2");
    // JZ not taken (carry set must not matter), then taken
    drive("jz0_t0",       4'h8, 1, 0, 0, 0, 0, 0, 0, "T0");
    drive("jz0_t1",       4'h8, 1, 0, 0, 0, 0, 1, 0, "T1");
    drive("jz0_t2",       4'h8, 1, 0, 0, 0, 0, 2, 0, "IDLE");
    drive("jz1_t0",       4'h8, 0, 1, 0, 0, 0, 0, 0, "T0");
    drive("jz1_t1",       4'h8, 0, 1, 0, 0, 0, 1, 0, "T1");
    drive("jz1_t2",       4'h8, 0, 1, 0, 0, 0, 2, 0, "JMP2");
    drive("jmp_t0",       4'h6, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("jmp_t1",       4'h6, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("jmp_t2",       4'h6, 0, 0, 0, 0, 0, 2, 0, "JMP2");
    // NOP and an undefined opcode both end after T1
    drive("nop_t0",       4'h0, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("nop_t1",       4'h0, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("op9_t0",       4'h9, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("op9_t1",       4'h9, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("out_t0",       4'hE, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("out_t1",       4'hE, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("out_t2",       4'hE, 0, 0, 0, 0, 0, 2, 0, "OUT2");
    drive("ldi_t0",       4'h5, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("ldi_t1",       4'h5, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("ldi_t2",       4'h5, 0, 0, 0, 0, 0, 2, 0, "LDI2");
    drive("sta_t0",       4'h4, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("sta_t1",       4'h4, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("sta_t2",       4'h4, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("sta_t3",       4'h4, 0, 0, 0, 0, 0, 3, 0, "STA3");
    drive("add_t0",       4'h2, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("add_t1",       4'h2, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("add_t2",       4'h2, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("add_t3",       4'h2, 0, 0, 0, 0, 0, 3, 0, "ADD3");
    drive("add_t4",       4'h2, 0, 0, 0, 0, 0, 4, 0, "ADD4");
    // HLT, ten held cycles, resume into a fresh LDA
    drive("hlt_t0",       4'hF, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("hlt_t1",       4'hF, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("hlt_t2",       4'hF, 0, 0, 0, 0, 0, 2, 0, "IDLE");
    for (int i = 0; i < 10; i++) begin
      drive("halt_hold",  4'hF, 1, 1, 0, 0, 0, 0, 1, "IDLE");
    end
    drive("halt_resume",  4'h1, 0, 0, 0, 1, 0, 0, 1, "IDLE");
    drive("res_lda_t0",   4'h1, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("res_lda_t1",   4'h1, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("res_lda_t2",   4'h1, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("res_lda_t3",   4'h1, 0, 0, 0, 0, 0, 3, 0, "LDA3");
    // PC overflow at T0: T0 still asserted, then HALT
    drive("ovf_t0",       4'h1, 0, 0, 1, 0, 0, 0, 0, "T0");
    drive("ovf_halted",   4'h1, 0, 0, 0, 0, 0, 0, 1, "IDLE");
    drive("ovf_resume",   4'h2, 0, 0, 0, 1, 0, 0, 1, "IDLE");
    // ADD aborted by reset during T3
    drive("rst_add_t0",   4'h2, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("rst_add_t1",   4'h2, 0, 0, 0, 0, 0, 1, 0, "T1");
    drive("rst_add_t2",   4'h2, 0, 0, 0, 0, 0, 2, 0, "ADDR");
    drive("rst_in_t3",    4'h2, 0, 0, 0, 0, 1, 0, 0, "IDLE");
    drive("rst_rel_t0",   4'h2, 0, 0, 0, 0, 0, 0, 0, "T0");
    drive("rst_rel_t1",   4'h2, 0, 0, 0, 0, 0, 1, 0, "T1");

    // Random opcodes/flags; only the bus-driver monitor judges these cycles.
    for (int i = 0; i < 10000; i++) begin
      bus.i_opcode      = 4'($urandom_range(0, 15));
      bus.i_carry_flag  = 1'($urandom_range(0, 1));
      bus.i_zero_flag   = 1'($urandom_range(0, 1));
      bus.i_pc_overflow = ($urandom_range(0, 15) == 0);
      bus.i_resume      = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end

    bus.i_opcode      = 4'h0;
    bus.i_pc_overflow = 1'b0;
    bus.i_resume      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
